led_pattern_sequencer: RTL and testbench
========================================

# led_pattern_sequencer

Autonomous sequencer that plays a programmed table of 8-bit LED patterns onto the LED PIO at a programmable step rate. The CPU sets it up through an Avalon-MM CSR slave. Sequencing is then handled by the block's Avalon-MM write master, which drives the PIO data register at offset 0. It sits between the system interconnect and the LED PIO and offloads blink and chase patterns from software.

## Interface
- DEPTH, 8, number of pattern table entries (power of two, ≤ 8 so the table fits CSR offsets 8–15)
- DATA_W, 8, pattern width; matches the LED PIO width
- DIV_W, 24, step divider width
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- s_address  in  4  CSR word offset
- s_chipselect  in  1  CSR select
- s_write_n  in  1  CSR write strobe, active-low
- s_writedata  in  32  CSR write data
- s_readdata  out  32  CSR read data, combinational, zero-wait
- m_address  out  2  PIO word offset; always 0
- m_chipselect  out  1  PIO select
- m_write_n  out  1  PIO write strobe, active-low
- m_writedata  out  32  {zero-extend, pattern}
- m_waitrequest  in  1  stall from PIO; tie 0 if the PIO has no waitrequest
- irq  out  1  level interrupt: done & CTRL.irq_en

## Operation
- CSR map:
  - 0 CTRL: bit0 run, bit1 loop, bit2 irq_en.
  - 1 STATUS: bit0 busy (RO), bit1 done (W1C), bits[6:4] current index (RO).
  - 2 DIVIDER: DIV_W bits.
  - 3 LENGTH: bits[3:0].
  - 8..8+DEPTH-1: pattern table, DATA_W bits each.
  - Unmapped offsets read 0; writes to them are ignored. Unused upper bits read 0.
- Effective divider = max(DIVIDER, 1). Effective length = LENGTH clamped to the range 1..DEPTH.
- FSM states: IDLE, WRITE, WAIT.
  - IDLE: busy=0. When run=1 → index←0, go to WRITE.
  - WRITE: m_chipselect=1, m_write_n=0, m_writedata={0, table[index]}. Hold while m_waitrequest=1. When m_waitrequest=0 the transfer completes: count←effective divider, go to WAIT.
  - WAIT: count decrements each cycle. When count reaches 1:
    - If index < effective length−1 → index+1, go to WRITE.
    - Else if loop=1 → index←0, go to WRITE.
    - Else → done←1, run←0, go to IDLE.
- Clearing run:
  - In WAIT: go to IDLE on the next cycle.
  - In WRITE: the in-flight transfer completes first, then go to IDLE. A transfer is never aborted.
  - The LEDs keep the last pattern written.
- Setting run while busy has no effect. The index restarts only from IDLE.
- A write with STATUS.done=1 clears done. If a set and a clear of done occur in the same cycle, the set wins.
- CSR writes to a table entry take effect on the next cycle. A WRITE cycle that coincides with such a write uses the old value.
- DIVIDER changes apply at the next count reload. LENGTH is sampled at each step end.
- Reset values:
  - All CSRs, table entries, index, count, and done are 0; state is IDLE.
  - m_chipselect=0, m_write_n=1, m_address=0, m_writedata=0, irq=0.
  - Reset mid-transfer drops the strobe immediately.

## Timing
- Master outputs are registered. The first PIO write strobe is asserted 2 cycles after the CSR write that sets run: 1 cycle for the CSR register, 1 cycle for IDLE→WRITE.
- With no wait states, step period = effective divider + 1 cycles (1 WRITE + divider WAIT).
- done and irq assert on the cycle after the last WAIT cycle.
- s_readdata reflects the register state of the same cycle; no read side effects.

## Structure
- Package led_seq_pkg holds:
  - the state enum (IDLE/WRITE/WAIT)
  - CSR offset constants (CTRL=0, STATUS=1, DIVIDER=2, LENGTH=3, TABLE_BASE=8)
  - CTRL/STATUS bit positions
- Sub-module led_seq_table: a DEPTH×DATA_W register file with one write port (CSR) and two read ports (CSR readback, sequencer).
- Top level contains the CSR decode, FSM, divider counter, and index counter.

## Test plan
- Reset defaults: hold reset mid-run → all outputs at reset values, CSR reads return 0, irq=0.
- One-shot run: table={01,02,04}, LENGTH=3, DIVIDER=4, loop=0, irq_en=1, set run → three PIO writes of 0x01/0x02/0x04, 5 cycles apart; done=1, irq=1, run reads 0.
- Loop and stop: loop=1, LENGTH=2, DIVIDER=1 → writes alternate every 2 cycles. Clear run during WAIT → no further writes, busy=0 the next cycle.
- Wait states: hold m_waitrequest=1 for 3 cycles during WRITE → strobe and data are held stable; the step period stretches by 3 cycles.
- Boundaries: DIVIDER=0 and LENGTH=0 behave as 1 and 1. LENGTH=12 clamps to 8. A table write during WRITE of the same entry outputs the old value, and the new value on the next pass.
- done W1C: write STATUS=0x2 → done=0, irq=0. Write it again in the same cycle the sequence completes → done=1.

Source files
------------

// File: rtl/led_seq_pkg.sv
// rtl/led_seq_pkg.sv - shared types, CSR map and bit positions for the LED pattern sequencer
package led_seq_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_WRITE = 2'd1,
      ST_WAIT  = 2'd2
   } seq_state_e;

   localparam logic [3:0] CSR_CTRL       = 4'd0;
   localparam logic [3:0] CSR_STATUS     = 4'd1;
   localparam logic [3:0] CSR_DIVIDER    = 4'd2;
   localparam logic [3:0] CSR_LENGTH     = 4'd3;
   localparam logic [3:0] CSR_TABLE_BASE = 4'd8;

   localparam int CTRL_RUN     = 0;
   localparam int CTRL_LOOP    = 1;
   localparam int CTRL_IRQ_EN  = 2;
   localparam int STAT_BUSY    = 0;
   localparam int STAT_DONE    = 1;
   localparam int STAT_IDX_LSB = 4;

   // LENGTH of 0 plays one entry; anything past the table plays the whole table
   function automatic logic [4:0] eff_length(input logic [3:0] len, input int depth);
      if (len == 4'd0) begin
         return 5'd1;
      end else if (int'(len) > depth) begin
         return 5'(depth);
      end else begin
         return {1'b0, len};
      end
   endfunction

endpackage

// File: rtl/led_seq_table.sv
// rtl/led_seq_table.sv - pattern register file: one CSR write port, CSR and sequencer read ports
module led_seq_table #(
   parameter int DEPTH  = 8,
   parameter int DATA_W = 8,
   parameter int IDX_W  = 3
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              we_i,
   input  logic [IDX_W-1:0]  waddr_i,
   input  logic [DATA_W-1:0] wdata_i,
   input  logic [IDX_W-1:0]  csr_raddr_i,
   output logic [DATA_W-1:0] csr_rdata_o,
   input  logic [IDX_W-1:0]  seq_raddr_i,
   output logic [DATA_W-1:0] seq_rdata_o
);

   logic [DATA_W-1:0] mem_q [DEPTH];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   // Reads see the pre-write contents during the cycle of a CSR write
   assign csr_rdata_o = mem_q[csr_raddr_i];
   assign seq_rdata_o = mem_q[seq_raddr_i];

endmodule

// File: rtl/led_pattern_sequencer.sv
// rtl/led_pattern_sequencer.sv - CSR slave plus write master that steps a pattern table onto the LED PIO
module led_pattern_sequencer
   import led_seq_pkg::*;
#(
   parameter int DEPTH  = 8,
   parameter int DATA_W = 8,
   parameter int DIV_W  = 24
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [3:0]  s_address,
   input  logic        s_chipselect,
   input  logic        s_write_n,
   input  logic [31:0] s_writedata,
   output logic [31:0] s_readdata,
   output logic [1:0]  m_address,
   output logic        m_chipselect,
   output logic        m_write_n,
   output logic [31:0] m_writedata,
   input  logic        m_waitrequest,
   output logic        irq
);

   localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   seq_state_e        state_q, state_d;
   logic [2:0]        ctrl_q, ctrl_d;
   logic              done_q, done_d;
   logic [DIV_W-1:0]  div_q, div_d;
   logic [DIV_W-1:0]  count_q, count_d;
   logic [3:0]        len_q, len_d;
   logic [IDX_W-1:0]  index_q, index_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;

   logic              csr_we, tbl_hit;
   logic              wr_ctrl, wr_status, wr_div, wr_len, wr_tbl;
   logic              sw_run, done_set, load_wdata, last_step;
   logic [4:0]        eff_len;
   logic [DIV_W-1:0]  eff_div;
   logic [DATA_W-1:0] tbl_csr_rdata, tbl_seq_rdata;
   logic              unused_wdata_hi;

   assign csr_we    = s_chipselect & ~s_write_n;
   assign tbl_hit   = (s_address >= CSR_TABLE_BASE) && (int'(s_address[2:0]) < DEPTH);
   assign wr_ctrl   = csr_we && (s_address == CSR_CTRL);
   assign wr_status = csr_we && (s_address == CSR_STATUS);
   assign wr_div    = csr_we && (s_address == CSR_DIVIDER);
   assign wr_len    = csr_we && (s_address == CSR_LENGTH);
   assign wr_tbl    = csr_we && tbl_hit;

   assign unused_wdata_hi = ^s_writedata[31:DIV_W];

   // Software's view of run this cycle, so a stop request is acted on without a register delay
   assign sw_run    = wr_ctrl ? s_writedata[CTRL_RUN] : ctrl_q[CTRL_RUN];
   assign eff_div   = (div_q == '0) ? DIV_W'(1) : div_q;
   assign eff_len   = eff_length(len_q, DEPTH);
   assign last_step = ((5'(index_q) + 5'd1) >= eff_len);

   led_seq_table #(
      .DEPTH  (DEPTH),
      .DATA_W (DATA_W),
      .IDX_W  (IDX_W)
   ) u_table (
      .clk         (clk),
      .reset       (reset),
      .we_i        (wr_tbl),
      .waddr_i     (s_address[IDX_W-1:0]),
      .wdata_i     (s_writedata[DATA_W-1:0]),
      .csr_raddr_i (s_address[IDX_W-1:0]),
      .csr_rdata_o (tbl_csr_rdata),
      .seq_raddr_i (index_d),
      .seq_rdata_o (tbl_seq_rdata)
   );

   always_comb begin
      ctrl_d = ctrl_q;
      if (wr_ctrl) begin
         ctrl_d = s_writedata[2:0];
      end
      if (done_set) begin
         ctrl_d[CTRL_RUN] = 1'b0;
      end
      done_d = done_set | (done_q & ~(wr_status & s_writedata[STAT_DONE]));
      div_d  = wr_div ? s_writedata[DIV_W-1:0] : div_q;
      len_d  = wr_len ? s_writedata[3:0] : len_q;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ctrl_q <= '0;
         done_q <= 1'b0;
         div_q  <= '0;
         len_q  <= '0;
      end else begin
         ctrl_q <= ctrl_d;
         done_q <= done_d;
         div_q  <= div_d;
         len_q  <= len_d;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= ST_IDLE;
         index_q <= '0;
         count_q <= '0;
         wdata_q <= '0;
      end else begin
         state_q <= state_d;
         index_q <= index_d;
         count_q <= count_d;
         wdata_q <= wdata_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      index_d    = index_q;
      count_d    = count_q;
      done_set   = 1'b0;
      load_wdata = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (ctrl_q[CTRL_RUN]) begin
               index_d    = '0;
               load_wdata = 1'b1;
               state_d    = ST_WRITE;
            end
         end
         ST_WRITE: begin
            // A started transfer always finishes; stop is only honoured once it completes
            if (!m_waitrequest) begin
               if (sw_run) begin
                  count_d = eff_div;
                  state_d = ST_WAIT;
               end else begin
                  state_d = ST_IDLE;
               end
            end
         end
         ST_WAIT: begin
            if (!sw_run) begin
               state_d = ST_IDLE;
            end else if (count_q <= DIV_W'(1)) begin
               if (!last_step) begin
                  index_d    = index_q + IDX_W'(1);
                  load_wdata = 1'b1;
                  state_d    = ST_WRITE;
               end else if (ctrl_q[CTRL_LOOP]) begin
                  index_d    = '0;
                  load_wdata = 1'b1;
                  state_d    = ST_WRITE;
               end else begin
                  done_set = 1'b1;
                  state_d  = ST_IDLE;
               end
            end else begin
               count_d = count_q - DIV_W'(1);
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
      wdata_d = load_wdata ? tbl_seq_rdata : wdata_q;
   end

   always_comb begin
      m_chipselect = (state_q == ST_WRITE);
      m_write_n    = (state_q != ST_WRITE);
      m_address    = 2'b00;
      m_writedata  = 32'(wdata_q);
   end

   assign irq = done_q & ctrl_q[CTRL_IRQ_EN];

   always_comb begin
      s_readdata = '0;
      case (s_address)
         CSR_CTRL:    s_readdata = 32'(ctrl_q);
         CSR_STATUS:  s_readdata = {25'd0, 3'(index_q), 2'b00, done_q, (state_q != ST_IDLE)};
         CSR_DIVIDER: s_readdata = 32'(div_q);
         CSR_LENGTH:  s_readdata = 32'(len_q);
         default: begin
            if (tbl_hit) begin
               s_readdata = 32'(tbl_csr_rdata);
            end
         end
      endcase
   end

endmodule

// File: tb/tb_led_pattern_sequencer.sv
// tb/tb_led_pattern_sequencer.sv - directed self-checking bench for led_pattern_sequencer
module tb_led_pattern_sequencer;

   logic        clk = 1'b0;
   logic        reset;
   logic [3:0]  s_address;
   logic        s_chipselect;
   logic        s_write_n;
   logic [31:0] s_writedata;
   logic [31:0] s_readdata;
   logic [1:0]  m_address;
   logic        m_chipselect;
   logic        m_write_n;
   logic [31:0] m_writedata;
   logic        m_waitrequest;
   logic        irq;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;
   logic [31:0] wr_data [$];
   int          wr_cyc  [$];

   led_pattern_sequencer dut (
      .clk           (clk),
      .reset         (reset),
      .s_address     (s_address),
      .s_chipselect  (s_chipselect),
      .s_write_n     (s_write_n),
      .s_writedata   (s_writedata),
      .s_readdata    (s_readdata),
      .m_address     (m_address),
      .m_chipselect  (m_chipselect),
      .m_write_n     (m_write_n),
      .m_writedata   (m_writedata),
      .m_waitrequest (m_waitrequest),
      .irq           (irq)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Logs every PIO write that completes at the coming rising edge
   always @(negedge clk) begin
      #2;
      if (!reset && m_chipselect && !m_write_n && !m_waitrequest) begin
         wr_data.push_back(m_writedata);
         wr_cyc.push_back(cyc);
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic csr_write(input logic [3:0] a, input logic [31:0] d, output int k);
      s_address = a; s_writedata = d; s_chipselect = 1'b1; s_write_n = 1'b0;
      k = cyc;
      @(negedge clk);
      s_chipselect = 1'b0; s_write_n = 1'b1;
   endtask

   task automatic csr_read(input logic [3:0] a, output logic [31:0] d);
      s_address = a; s_chipselect = 1'b1; s_write_n = 1'b1;
      #1;
      d = s_readdata;
      s_chipselect = 1'b0;
   endtask

   task automatic goto_cyc(input int n);
      while (cyc < n) @(negedge clk);
   endtask

   task automatic test_reset;
      logic [31:0] rd;
      logic [3:0]  addrs [5];
      int k, kd;
      addrs = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd8};
      reset = 1'b1; s_address = '0; s_chipselect = 1'b0; s_write_n = 1'b1;
      s_writedata = '0; m_waitrequest = 1'b0;
      repeat (2) @(negedge clk);
      n_checks++; if (m_chipselect !== 1'b0) begin n_fail++; $display("FAIL rst_cs: got %b want 0", m_chipselect); end
      n_checks++; if (m_write_n !== 1'b1) begin n_fail++; $display("FAIL rst_wn: got %b want 1", m_write_n); end
      n_checks++; if (m_address !== 2'd0) begin n_fail++; $display("FAIL rst_addr: got %h want 0", m_address); end
      n_checks++; if (m_writedata !== 32'd0) begin n_fail++; $display("FAIL rst_wd: got %h want 0", m_writedata); end
      n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL rst_irq: got %b want 0", irq); end
      reset = 1'b0;
      csr_write(4'd8, 32'h3C, kd);
      csr_write(4'd3, 32'd1, kd);
      csr_write(4'd2, 32'd5, kd);
      csr_write(4'd0, 32'h3, k);
      goto_cyc(k + 2);
      #1;
      n_checks++; if (m_chipselect !== 1'b1) begin n_fail++; $display("FAIL midrun_cs: got %b want 1", m_chipselect); end
      n_checks++; if (m_writedata !== 32'h3C) begin n_fail++; $display("FAIL midrun_wd: got %h want 3c", m_writedata); end
      m_waitrequest = 1'b1;
      #2 reset = 1'b1;
      #1;
      n_checks++; if (m_chipselect !== 1'b0) begin n_fail++; $display("FAIL rst_drop_cs: got %b want 0", m_chipselect); end
      n_checks++; if (m_write_n !== 1'b1) begin n_fail++; $display("FAIL rst_drop_wn: got %b want 1", m_write_n); end
      n_checks++; if (m_writedata !== 32'd0) begin n_fail++; $display("FAIL rst_drop_wd: got %h want 0", m_writedata); end
      @(negedge clk);
      reset = 1'b0; m_waitrequest = 1'b0;
      for (int i = 0; i < 5; i++) begin
         csr_read(addrs[i], rd);
         n_checks++; if (rd !== 32'd0) begin n_fail++; $display("FAIL rst_csr%0d: got %h want 0", addrs[i], rd); end
      end
      repeat (3) @(negedge clk);
      n_checks++; if (m_chipselect !== 1'b0) begin n_fail++; $display("FAIL rst_idle_cs: got %b want 0", m_chipselect); end
      n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL rst_idle_irq: got %b want 0", irq); end
   endtask

   task automatic test_one_shot;
      logic [31:0] rd;
      logic [31:0] exp_d [3];
      int k, kd;
      exp_d = '{32'h01, 32'h02, 32'h04};
      csr_write(4'd8, 32'h01, kd);
      csr_write(4'd9, 32'h02, kd);
      csr_write(4'd10, 32'h04, kd);
      csr_write(4'd3, 32'd3, kd);
      csr_write(4'd2, 32'd4, kd);
      wr_data.delete(); wr_cyc.delete();
      csr_write(4'd0, 32'h5, k);
      goto_cyc(k + 16);
      n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL os_irq_early: got %b want 0", irq); end
      goto_cyc(k + 17);
      n_checks++; if (irq !== 1'b1) begin n_fail++; $display("FAIL os_irq: got %b want 1", irq); end
      n_checks++; if (wr_data.size() !== 3) begin n_fail++; $display("FAIL os_count: got %0d want 3", wr_data.size()); end
      if (wr_data.size() == 3) begin
         for (int i = 0; i < 3; i++) begin
            n_checks++; if (wr_data[i] !== exp_d[i]) begin n_fail++; $display("FAIL os_data%0d: got %h want %h", i, wr_data[i], exp_d[i]); end
            n_checks++; if (wr_cyc[i] !== k + 2 + 5 * i) begin n_fail++; $display("FAIL os_cyc%0d: got %0d want %0d", i, wr_cyc[i], k + 2 + 5 * i); end
         end
      end
      csr_read(4'd1, rd);
      n_checks++; if (rd !== 32'h22) begin n_fail++; $display("FAIL os_status: got %h want 22", rd); end
      csr_read(4'd0, rd);
      n_checks++; if (rd !== 32'h4) begin n_fail++; $display("FAIL os_ctrl: got %h want 4", rd); end
   endtask

   task automatic test_loop_stop;
      logic [31:0] rd;
      int k, kd;
      csr_write(4'd1, 32'h2, kd);
      csr_write(4'd0, 32'h0, kd);
      csr_write(4'd8, 32'h11, kd);
      csr_write(4'd9, 32'h22, kd);
      csr_write(4'd3, 32'd2, kd);
      csr_write(4'd2, 32'd1, kd);
      wr_data.delete(); wr_cyc.delete();
      csr_write(4'd0, 32'h3, k);
      goto_cyc(k + 9);
      csr_write(4'd0, 32'h0, kd);
      csr_read(4'd1, rd);
      n_checks++; if (rd !== 32'h10) begin n_fail++; $display("FAIL lp_status: got %h want 10", rd); end
      n_checks++; if (wr_data.size() !== 4) begin n_fail++; $display("FAIL lp_count: got %0d want 4", wr_data.size()); end
      if (wr_data.size() == 4) begin
         for (int i = 0; i < 4; i++) begin
            n_checks++; if (wr_data[i] !== ((i % 2 == 0) ? 32'h11 : 32'h22)) begin n_fail++; $display("FAIL lp_data%0d: got %h", i, wr_data[i]); end
            n_checks++; if (wr_cyc[i] !== k + 2 + 2 * i) begin n_fail++; $display("FAIL lp_cyc%0d: got %0d want %0d", i, wr_cyc[i], k + 2 + 2 * i); end
         end
      end
      goto_cyc(k + 20);
      n_checks++; if (wr_data.size() !== 4) begin n_fail++; $display("FAIL lp_after_stop: got %0d writes want 4", wr_data.size()); end
      n_checks++; if (m_writedata !== 32'h22) begin n_fail++; $display("FAIL lp_hold: got %h want 22", m_writedata); end
   endtask

   task automatic test_wait_states;
      int k, kd;
      csr_write(4'd8, 32'h33, kd);
      csr_write(4'd9, 32'h44, kd);
      csr_write(4'd3, 32'd2, kd);
      csr_write(4'd2, 32'd2, kd);
      wr_data.delete(); wr_cyc.delete();
      m_waitrequest = 1'b1;
      csr_write(4'd0, 32'h1, k);
      for (int c = 2; c <= 4; c++) begin
         goto_cyc(k + c);
         #1;
         n_checks++; if (m_chipselect !== 1'b1 || m_write_n !== 1'b0) begin n_fail++; $display("FAIL ws_strobe%0d: got cs=%b wn=%b want 1/0", c, m_chipselect, m_write_n); end
         n_checks++; if (m_writedata !== 32'h33) begin n_fail++; $display("FAIL ws_data%0d: got %h want 33", c, m_writedata); end
      end
      goto_cyc(k + 5);
      m_waitrequest = 1'b0;
      goto_cyc(k + 12);
      n_checks++; if (wr_data.size() !== 2) begin n_fail++; $display("FAIL ws_count: got %0d want 2", wr_data.size()); end
      if (wr_data.size() == 2) begin
         n_checks++; if (wr_cyc[0] !== k + 5) begin n_fail++; $display("FAIL ws_cyc0: got %0d want %0d", wr_cyc[0], k + 5); end
         n_checks++; if (wr_cyc[1] !== k + 8) begin n_fail++; $display("FAIL ws_cyc1: got %0d want %0d", wr_cyc[1], k + 8); end
         n_checks++; if (wr_data[1] !== 32'h44) begin n_fail++; $display("FAIL ws_data_b: got %h want 44", wr_data[1]); end
      end
   endtask

   task automatic test_boundaries;
      logic [31:0] rd;
      int k, kd;
      csr_write(4'd1, 32'h2, kd);
      csr_write(4'd8, 32'h5A, kd);
      csr_write(4'd3, 32'd0, kd);
      csr_write(4'd2, 32'd0, kd);
      wr_data.delete(); wr_cyc.delete();
      csr_write(4'd0, 32'h1, k);
      goto_cyc(k + 4);
      csr_read(4'd1, rd);
      n_checks++; if (rd !== 32'h02) begin n_fail++; $display("FAIL b0_status: got %h want 02", rd); end
      n_checks++; if (wr_data.size() !== 1) begin n_fail++; $display("FAIL b0_count: got %0d want 1", wr_data.size()); end
      if (wr_data.size() == 1) begin
         n_checks++; if (wr_data[0] !== 32'h5A || wr_cyc[0] !== k + 2) begin n_fail++; $display("FAIL b0_write: got %h@%0d want 5a@%0d", wr_data[0], wr_cyc[0], k + 2); end
      end

      csr_write(4'd1, 32'h2, kd);
      for (int i = 0; i < 8; i++) csr_write(4'(8 + i), 32'h80 + i, kd);
      csr_write(4'd3, 32'd12, kd);
      csr_write(4'd2, 32'd1, kd);
      wr_data.delete(); wr_cyc.delete();
      csr_write(4'd0, 32'h1, k);
      goto_cyc(k + 18);
      csr_read(4'd1, rd);
      n_checks++; if (rd !== 32'h72) begin n_fail++; $display("FAIL b12_status: got %h want 72", rd); end
      csr_read(4'd3, rd);
      n_checks++; if (rd !== 32'hC) begin n_fail++; $display("FAIL b12_length: got %h want c", rd); end
      n_checks++; if (wr_data.size() !== 8) begin n_fail++; $display("FAIL b12_count: got %0d want 8", wr_data.size()); end
      if (wr_data.size() == 8) begin
         for (int i = 0; i < 8; i++) begin
            n_checks++; if (wr_data[i] !== 32'h80 + i || wr_cyc[i] !== k + 2 + 2 * i) begin n_fail++; $display("FAIL b12_w%0d: got %h@%0d want %h@%0d", i, wr_data[i], wr_cyc[i], 32'h80 + i, k + 2 + 2 * i); end
         end
      end

      csr_write(4'd1, 32'h2, kd);
      csr_write(4'd8, 32'h10, kd);
      csr_write(4'd3, 32'd1, kd);
      csr_write(4'd2, 32'd3, kd);
      wr_data.delete(); wr_cyc.delete();
      csr_write(4'd0, 32'h3, k);
      goto_cyc(k + 2);
      #1;
      n_checks++; if (m_writedata !== 32'h10) begin n_fail++; $display("FAIL tw_cur: got %h want 10", m_writedata); end
      csr_write(4'd8, 32'h20, kd);
      goto_cyc(k + 7);
      csr_write(4'd0, 32'h0, kd);
      n_checks++; if (wr_data.size() !== 2) begin n_fail++; $display("FAIL tw_count: got %0d want 2", wr_data.size()); end
      if (wr_data.size() == 2) begin
         n_checks++; if (wr_data[0] !== 32'h10) begin n_fail++; $display("FAIL tw_old: got %h want 10", wr_data[0]); end
         n_checks++; if (wr_data[1] !== 32'h20 || wr_cyc[1] !== k + 6) begin n_fail++; $display("FAIL tw_new: got %h@%0d want 20@%0d", wr_data[1], wr_cyc[1], k + 6); end
      end
      csr_read(4'd8, rd);
      n_checks++; if (rd !== 32'h20) begin n_fail++; $display("FAIL tw_readback: got %h want 20", rd); end
   endtask

   task automatic test_done_w1c;
      logic [31:0] rd;
      int k, kd;
      csr_write(4'd1, 32'h2, kd);
      csr_write(4'd8, 32'h99, kd);
      csr_write(4'd3, 32'd1, kd);
      csr_write(4'd2, 32'd2, kd);
      csr_write(4'd0, 32'h5, k);
      goto_cyc(k + 5);
      n_checks++; if (irq !== 1'b1) begin n_fail++; $display("FAIL w1c_irq_set: got %b want 1", irq); end
      csr_write(4'd1, 32'h2, kd);
      csr_read(4'd1, rd);
      n_checks++; if (rd !== 32'h00) begin n_fail++; $display("FAIL w1c_clear: got %h want 00", rd); end
      n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL w1c_irq_clr: got %b want 0", irq); end
      csr_write(4'd0, 32'h5, k);
      goto_cyc(k + 4);
      csr_write(4'd1, 32'h2, kd);
      csr_read(4'd1, rd);
      n_checks++; if (rd !== 32'h02) begin n_fail++; $display("FAIL w1c_set_wins: got %h want 02", rd); end
      n_checks++; if (irq !== 1'b1) begin n_fail++; $display("FAIL w1c_set_irq: got %b want 1", irq); end
      csr_write(4'd1, 32'h2, kd);
      #1;
      n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL w1c_final: got %b want 0", irq); end
   endtask

   initial begin
      test_reset();
      test_one_shot();
      test_loop_stop();
      test_wait_states();
      test_boundaries();
      test_done_w1c();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
